// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the pc, reads a 1024-word combinational imem and
// hands each word to decode through a single-entry valid/ready output stage.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  imem_address,
    input  logic [31:0] imem_instruction,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        HALT  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;
    logic        transfer;

    // Misaligned or beyond the 4 KiB instruction memory.
    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    endfunction

    assign transfer = valid_q & id_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;

        if (state_q == FAULT) begin
            valid_d = 1'b0;
        end else begin
            if (transfer) begin
                count_d = count_q + 32'd1;
                valid_d = 1'b0;
            end

            // Priority: redirect > halt > start > sequential fetch.
            if (redirect_valid) begin
                valid_d = 1'b0;
                if (bad_addr(redirect_pc)) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                end else begin
                    pc_d = redirect_pc;
                end
            end else if (halt_req) begin
                if (state_q == RUN) begin
                    state_d = HALT;
                end
            end else if (start && (state_q != RUN)) begin
                state_d = RUN;
            end else if ((state_q == RUN) && (!valid_q || id_ready)) begin
                if (bad_addr(pc_q)) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    valid_d    = 1'b0;
                end else begin
                    instr_d = imem_instruction;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'd0;
            instr_q    <= 32'd0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_address = pc_q[11:2];
    assign if_valid     = valid_q;
    assign if_pc        = if_pc_q;
    assign if_instr     = instr_q;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign fetch_count  = count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: per-cycle vector table plus a delivery scoreboard
// that checks every decode handshake against the expected instruction stream.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  imem_address;
    logic [31:0] imem_instruction;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;
    logic [1:0]  state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Memory image: word i holds 32'h1000_0000 + i.
    assign imem_instruction = 32'h1000_0000 + {22'd0, imem_address};

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .id_ready         (id_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .halt_req         (halt_req),
        .fault            (fault),
        .fault_pc         (fault_pc),
        .fetch_count      (fetch_count),
        .state            (state)
    );

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        hr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [9:0]  eaddr;
        logic [1:0]  est;
        logic [31:0] ecnt;
        logic        ef;
        logic [31:0] efpc;
    } vec_t;

    vec_t        tbl[24];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] iw(input logic [31:0] word);
        return 32'h1000_0000 + word;
    endfunction

    function automatic vec_t mk(input logic st, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic hr,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic [9:0] eaddr,
                                input logic [1:0] est, input logic [31:0] ecnt,
                                input logic ef, input logic [31:0] efpc);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hr = hr;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
        v.est = est; v.ecnt = ecnt; v.ef = ef; v.efpc = efpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] einstr, input logic [9:0] eaddr,
                            input logic [1:0] est, input logic [31:0] ecnt,
                            input logic ef, input logic [31:0] efpc);
        chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, ev});
        chk({tag, ".if_pc"}, if_pc, epc);
        chk({tag, ".if_instr"}, if_instr, einstr);
        chk({tag, ".imem_address"}, {22'd0, imem_address}, {22'd0, eaddr});
        chk({tag, ".state"}, {30'd0, state}, {30'd0, est});
        chk({tag, ".fetch_count"}, fetch_count, ecnt);
        chk({tag, ".fault"}, {31'd0, fault}, {31'd0, ef});
        chk({tag, ".fault_pc"}, fault_pc, efpc);
    endtask

    task automatic drive(input logic st, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic hr);
        start = st; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs change 1 after posedge, so negedge sees a stable handshake.
    always @(negedge clk) begin
        if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb.unexpected_xfer_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("xfer pc=%h instr=%h (expected pc=%h)", if_pc, if_instr, e);
                chk("sb.xfer_pc", if_pc, e);
                chk("sb.xfer_instr", if_instr, iw({2'b00, e[31:2]}));
            end
        end
    end

    initial begin
        tbl[0]  = mk(1,1,0,0,0,     0,32'h000,32'd0,       10'h000,2'd1,0, 0,0);
        tbl[1]  = mk(0,1,0,0,0,     1,32'h000,iw(32'h000), 10'h001,2'd1,0, 0,0);
        tbl[2]  = mk(0,1,0,0,0,     1,32'h004,iw(32'h001), 10'h002,2'd1,1, 0,0);
        tbl[3]  = mk(0,1,0,0,0,     1,32'h008,iw(32'h002), 10'h003,2'd1,2, 0,0);
        tbl[4]  = mk(0,0,0,0,0,     1,32'h008,iw(32'h002), 10'h003,2'd1,2, 0,0);
        tbl[5]  = mk(0,0,0,0,0,     1,32'h008,iw(32'h002), 10'h003,2'd1,2, 0,0);
        tbl[6]  = mk(0,0,0,0,0,     1,32'h008,iw(32'h002), 10'h003,2'd1,2, 0,0);
        tbl[7]  = mk(0,1,0,0,0,     1,32'h00C,iw(32'h003), 10'h004,2'd1,3, 0,0);
        tbl[8]  = mk(0,1,0,0,0,     1,32'h010,iw(32'h004), 10'h005,2'd1,4, 0,0);
        tbl[9]  = mk(0,1,0,0,0,     1,32'h014,iw(32'h005), 10'h006,2'd1,5, 0,0);
        tbl[10] = mk(0,0,1,32'h40,0,0,32'h014,iw(32'h005), 10'h010,2'd1,5, 0,0);
        tbl[11] = mk(0,1,0,0,0,     1,32'h040,iw(32'h010), 10'h011,2'd1,5, 0,0);
        tbl[12] = mk(0,1,0,0,0,     1,32'h044,iw(32'h011), 10'h012,2'd1,6, 0,0);
        tbl[13] = mk(0,0,0,0,1,     1,32'h044,iw(32'h011), 10'h012,2'd2,6, 0,0);
        tbl[14] = mk(0,0,0,0,0,     1,32'h044,iw(32'h011), 10'h012,2'd2,6, 0,0);
        tbl[15] = mk(0,1,0,0,0,     0,32'h044,iw(32'h011), 10'h012,2'd2,7, 0,0);
        tbl[16] = mk(0,1,0,0,0,     0,32'h044,iw(32'h011), 10'h012,2'd2,7, 0,0);
        tbl[17] = mk(1,1,0,0,0,     0,32'h044,iw(32'h011), 10'h012,2'd1,7, 0,0);
        tbl[18] = mk(0,1,0,0,0,     1,32'h048,iw(32'h012), 10'h013,2'd1,7, 0,0);
        tbl[19] = mk(0,1,1,32'hFF8,0,0,32'h048,iw(32'h012),10'h3FE,2'd1,8, 0,0);
        tbl[20] = mk(0,1,0,0,0,     1,32'hFF8,iw(32'h3FE), 10'h3FF,2'd1,8, 0,0);
        tbl[21] = mk(0,1,0,0,0,     1,32'hFFC,iw(32'h3FF), 10'h000,2'd1,9, 0,0);
        tbl[22] = mk(0,1,0,0,0,     0,32'hFFC,iw(32'h3FF), 10'h000,2'd3,10,1,32'h1000);
        tbl[23] = mk(1,1,1,32'h200,1,0,32'hFFC,iw(32'h3FF),10'h000,2'd3,10,1,32'h1000);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 10'd0, 2'd0, 0, 0, 0);
        rst = 1'b0;

        // Main table: each row is one clock of stimulus and the state after that edge.
        exp_q.push_back(32'h000); exp_q.push_back(32'h004); exp_q.push_back(32'h008);
        exp_q.push_back(32'h00C); exp_q.push_back(32'h010); exp_q.push_back(32'h040);
        exp_q.push_back(32'h044); exp_q.push_back(32'h048); exp_q.push_back(32'hFF8);
        exp_q.push_back(32'hFFC);
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].st, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].hr);
            step();
            chk_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einstr,
                     tbl[i].eaddr, tbl[i].est, tbl[i].ecnt, tbl[i].ef, tbl[i].efpc);
        end
        chk("table.sb_drained", exp_q.size(), 0);

        // Asynchronous reset while in FAULT, mid-cycle.
        drive(0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 chk_outs("arst_fault", 0, 0, 0, 10'd0, 2'd0, 0, 0, 0);
        #1 rst = 1'b0;

        // IDLE redirect preloads pc; start; fetch from the new pc.
        drive(0, 0, 1, 32'h100, 0); step();
        chk_outs("idle_redir", 0, 0, 0, 10'h040, 2'd0, 0, 0, 0);
        drive(1, 0, 0, 0, 0); step();
        chk_outs("idle_start", 0, 0, 0, 10'h040, 2'd1, 0, 0, 0);
        exp_q.push_back(32'h100);
        drive(0, 1, 0, 0, 0); step();
        chk_outs("first_load", 1, 32'h100, iw(32'h040), 10'h041, 2'd1, 0, 0, 0);
        step();
        chk_outs("second_load", 1, 32'h104, iw(32'h041), 10'h042, 2'd1, 1, 0, 0);

        // Asynchronous reset mid-stream, before the next edge can transfer 0x104.
        #1 rst = 1'b1;
        #1 chk_outs("arst_run", 0, 0, 0, 10'd0, 2'd0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        #1 rst = 1'b0;

        // Misaligned redirect while an entry is held -> absorbing FAULT.
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        chk_outs("held_entry", 1, 32'h000, iw(32'h000), 10'h001, 2'd1, 0, 0, 0);
        drive(0, 0, 1, 32'h42, 0); step();
        chk_outs("bad_redir", 0, 32'h000, iw(32'h000), 10'h001, 2'd3, 0, 1, 32'h42);
        drive(1, 1, 1, 32'h80, 0); step();
        chk_outs("fault_hold", 0, 32'h000, iw(32'h000), 10'h001, 2'd3, 0, 1, 32'h42);
        drive(0, 0, 0, 0, 0);
        chk("end.sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the 1024-word instruction memory (32-bit words, 10-bit word address, combinational read). It owns the program counter, drives the memory address, and registers each fetched instruction into a single-entry output stage handed to decode over a valid/ready handshake. It also applies control-flow redirects, halt/resume and start-up sequencing, and raises a sticky fault on misaligned or out-of-range fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into pc at reset; must be word-aligned and below 32'h0000_1000.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE or HALT and begin fetching at current pc.
- imem_address  out  10  word address to instruction memory = pc[11:2], combinational from pc register.
- imem_instruction  in  32  combinational read data for imem_address.
- if_valid  out  1  output stage holds an instruction.
- if_pc  out  32  byte address of if_instr.
- if_instr  out  32  registered instruction word.
- id_ready  in  1  decode accepts; transfer = if_valid & id_ready.
- redirect_valid  in  1  load redirect_pc this cycle (branch/jump/trap).
- redirect_pc  in  32  new byte address.
- halt_req  in  1  stop issuing new fetches.
- fault  out  1  sticky fault flag.
- fault_pc  out  32  offending address.
- fetch_count  out  32  number of completed transfers, wraps mod 2^32.
- state  out  2  IDLE=00, RUN=01, HALT=10, FAULT=11.

## Operation
- Reset values: pc=RESET_PC, state=IDLE, if_valid=0, if_pc=0, if_instr=0, fault=0, fault_pc=0, fetch_count=0.
- bad(a) = (a[1:0]!=0) | (a[31:12]!=0).
- load = (state==RUN) & !redirect_valid & !halt_req & !bad(pc) & (!if_valid | id_ready).
- On load: if_instr<=imem_instruction, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit, no saturation).
- Not load and transfer: if_valid<=0. if_pc/if_instr hold when not loading.
- fetch_count increments on every transfer in any state except FAULT, including a transfer in the same cycle as a redirect or halt.
- Priority per cycle (RUN, HALT, IDLE): redirect > halt_req > start > normal fetch.
- Redirect with bad(redirect_pc): state<=FAULT, fault<=1, fault_pc<=redirect_pc, if_valid<=0.
- Redirect, good address: pc<=redirect_pc, if_valid<=0 (wrong-path flush), state unchanged.
- IDLE: no fetches; start -> RUN; good redirect preloads pc and stays IDLE.
- RUN: halt_req -> HALT, no load that cycle, existing if_valid entry kept until transferred; RUN with bad(pc) at load opportunity (!if_valid | id_ready, no redirect/halt) -> FAULT, fault_pc<=pc, if_valid<=0. start ignored.
- HALT: no loads; pending entry still drains via handshake; start (no halt_req) -> RUN resuming at pc.
- FAULT: absorbing until rst; if_valid forced 0; all inputs ignored; fault_pc frozen.
- pc stepping from 32'h0000_0FFC gives 32'h0000_1000; next load opportunity faults with fault_pc=32'h0000_1000.

## Timing
- imem_address reflects pc with zero latency; if_instr valid one edge after the load edge.
- start sampled at edge N -> RUN after N; first load at N+1; if_valid=1 after N+1, if_pc=pc.
- With id_ready held 1: one instruction per cycle, back-to-back, no bubbles.
- id_ready=0 with if_valid=1: if_pc/if_instr/pc stable until the accepting edge.
- Redirect at edge R: one bubble; target instruction valid after R+1.
- rst assertion mid-operation: all registers return to reset values immediately (asynchronous), independent of clk.

## Test plan
- Memory loaded with word i = 32'h1000_0000+i; reset, start, id_ready=1 for 6 cycles -> if_pc 0,4,8,12,16,20, if_instr 10000000..10000005, fetch_count=6.
- Toggle id_ready low for 3 cycles while if_pc=8 -> if_pc/if_instr hold at 8/10000002, imem_address stays 3, resume at 12 with no gap or duplicate.
- Redirect to 32'h0000_0040 while if_valid=1, id_ready=0 -> if_valid=0 next cycle, then if_pc=0x40, if_instr=10000010; redirect to 32'h0000_0042 -> state=11, fault=1, fault_pc=32'h0000_0042, if_valid=0 until rst.
- Good redirect to 32'h0000_0FF8 then run -> delivers 0xFF8, 0xFFC, then FAULT with fault_pc=32'h0000_1000; no third delivery.
- halt_req pulse with pending entry and id_ready=0 -> state=HALT, entry held; id_ready=1 -> one transfer, fetch_count+1, no new loads; start -> resumes at next sequential pc.
- Assert rst asynchronously mid-stream and in FAULT -> all outputs at reset values before next clk edge; state=IDLE, pc=RESET_PC.
